fetch_unit: RTL

Instruction fetch and program-counter unit for the single-cycle MIPS core; it consumes the branch and jump targets produced by the immediate extender and supplies it with `nPC`. It owns the PC register, runs a request/acknowledge handshake with instruction memory, and holds each fetched instruction until the datapath retires it. The unit then selects the next PC and starts the next fetch.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/npc_mux.sv | 32 +++
 rtl/fetch_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end: next-PC select codes,
// fetch FSM states and the default reset PC.
package cpu_pkg;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10,
    HALT  = 2'b11
  } fetch_state_t;

endpackage

// File: rtl/npc_mux.sv
// Combinational next-PC selector; also flags a target that is not word aligned.
module npc_mux
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [31:0] b_instr,
  input  logic [31:0] j_instr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] seq_pc;

  assign seq_pc = pc + 32'd4;

  always_comb begin
    next_pc = seq_pc;
    case (npc_sel)
      NPC_SEQ:    next_pc = seq_pc;
      NPC_BRANCH: next_pc = branch_taken ? b_instr : seq_pc;
      NPC_JUMP:   next_pc = j_instr;
      NPC_JR:     next_pc = jr_target;
      default:    next_pc = seq_pc;
    endcase
  end

  assign misalign = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC unit: owns the PC, handshakes with instruction memory,
// holds each instruction until retired, then selects and fetches the next PC.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        retire,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [31:0] b_instr,
  input  logic [31:0] j_instr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] nPC,
  output logic [31:0] retired_cnt,
  output logic        misalign_err
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, instr_reg, cnt_reg;
  logic [31:0]  next_pc;
  logic         next_misalign;
  logic         fetch_done, retiring;

  npc_mux u_npc_mux (
    .pc           (pc_reg),
    .npc_sel      (npc_sel),
    .branch_taken (branch_taken),
    .b_instr      (b_instr),
    .j_instr      (j_instr),
    .jr_target    (jr_target),
    .next_pc      (next_pc),
    .misalign     (next_misalign)
  );

  assign fetch_done = (state_reg == FETCH) && imem_ack;
  assign retiring   = (state_reg == HOLD) && retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = FETCH;
      FETCH:   if (imem_ack) state_next = HOLD;
      HOLD:    if (retire) state_next = next_misalign ? HALT : FETCH;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Handshake/status outputs decode only from the state register.
  always_comb begin
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    misalign_err = 1'b0;
    case (state_reg)
      FETCH:   imem_req = 1'b1;
      HOLD:    instr_valid = 1'b1;
      HALT:    misalign_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      if (fetch_done) instr_reg <= imem_rdata;
      if (retiring) begin
        cnt_reg <= cnt_reg + 32'd1;
        // A misaligned target halts with the PC of the offending instruction.
        if (!next_misalign) pc_reg <= next_pc;
      end
    end
  end

  assign pc          = pc_reg;
  assign nPC         = pc_reg + 32'd4;
  assign imem_addr   = pc_reg;
  assign instr       = instr_reg;
  assign retired_cnt = cnt_reg;

endmodule
